imem_loader: RTL and testbench
==============================

IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 SHALL have parameter ADDR_SIZE, default 6: instruction store holds 2**ADDR_SIZE 32-bit words.
REQ-002 SHALL have parameter HOLD_CYCLES, default 4: cycles the core is held in reset after loading completes; legal range 1..15.
REQ-003 SHALL have one clock; reset is asynchronous and active-high, with ports named clock and reset.
REQ-004 clock  input  1  rising-edge clock for all state.
REQ-005 reset  input  1  asynchronous, active-high block reset.
REQ-006 load_valid  input  1  load_data/load_last valid this cycle.
REQ-007 load_ready  output  1  block accepts a load word this cycle.
REQ-008 load_data  input  32  instruction word to store.
REQ-009 load_last  input  1  marks the final word of the program.
REQ-010 reload  input  1  single-cycle request to start a new program load.
REQ-011 raddr  input  32  word address from core fetch.
REQ-012 instr  output  32  instruction returned to core, combinational from raddr.
REQ-013 core_reset  output  1  synchronous reset to downstream core.
REQ-014 load_count  output  ADDR_SIZE+1  number of words stored by the last load.
REQ-015 overflow  output  1  sticky: store filled without load_last.

Function
REQ-016 SHALL implement three states: LOAD, HOLD, RUN.
REQ-017 LOAD: load_ready=1, core_reset=1; a word transfers on load_valid&&load_ready and is written to mem[wptr], then wptr and load_count increment by 1 in the same edge.
REQ-018 LOAD->HOLD when the transferred word has load_last=1, or when it is written to index 2**ADDR_SIZE-1; in the latter case, without load_last, overflow SHALL be set to 1.
REQ-019 load_valid while load_ready=0 SHALL be ignored; no write, no counter change.
REQ-020 HOLD: load_ready=0, core_reset=1 for exactly HOLD_CYCLES cycles (down-counter), then HOLD->RUN.
REQ-021 RUN: load_ready=0, core_reset=0; load_valid ignored.
REQ-022 reload=1 in RUN or HOLD SHALL go to LOAD on the next edge: wptr=0, load_count=0, overflow=0, core_reset=1 from that cycle; reload in LOAD is ignored.
REQ-023 instr SHALL be mem[raddr[ADDR_SIZE-1:0]] only when state==RUN, raddr[31:ADDR_SIZE]==0 and raddr[ADDR_SIZE-1:0] < load_count; otherwise 32'h0000000D (break).
REQ-024 In LOAD/HOLD instr SHALL be 32'h00000000 (nop), overriding REQ-023.
REQ-025 A zero-length program is impossible: at least one word is transferred before HOLD.
REQ-026 Memory contents SHALL not be reset; unloaded words never reach instr (REQ-023).

Reset
REQ-027 On reset: state=LOAD, wptr=0, load_count=0, overflow=0, hold counter=0, core_reset=1, load_ready=1 (after release), instr=0.
REQ-028 Reset asserted mid-load or mid-run SHALL abort immediately; words already written remain in memory but load_count=0, so none of them is fetched.

Structure
REQ-029 Shared package imem_pkg SHALL hold the state enum, BREAK_INSTR=32'h0000000D and NOP_INSTR=32'h00000000.
REQ-030 Storage SHALL be one sub-module, imem_array: single write port and one asynchronous read port, no reset.
REQ-031 Target size 120-300 lines of RTL.

Verification
REQ-032 Load 3 words {0x20010005, 0x20020007, 0x0000000D}, last on third, no reload -> core_reset=1 for 4 cycles after acceptance, then 0; raddr 0..2 return those words; raddr 3 returns 0x0000000D.
REQ-033 Drive 64 words with load_last never set -> load_ready drops after 64th, overflow=1, load_count=64, RUN after 4 hold cycles.
REQ-034 load_valid toggling 1/0 each cycle over 4 words -> exactly 4 writes, load_count=4, no duplicates.
REQ-035 In RUN, pulse reload -> next cycle state LOAD, core_reset=1, load_count=0, instr=0; load 1 word -> that word at raddr 0 after hold.
REQ-036 Assert reset during HOLD countdown -> core_reset stays 1, load_count=0, load_ready=1 after release, nothing fetched.
REQ-037 raddr=0x00000040 in RUN with full store -> instr=0x0000000D.

Source files
------------

// File: rtl/imem_pkg.sv
// Shared definitions for the instruction-memory loader: FSM state encoding
// and the two fixed instruction words handed to the core in place of
// real program data.
package imem_pkg;

    typedef enum logic [1:0] {
        ST_LOAD = 2'd0,
        ST_HOLD = 2'd1,
        ST_RUN  = 2'd2
    } state_t;

    localparam logic [31:0] BREAK_INSTR = 32'h0000_000D;
    localparam logic [31:0] NOP_INSTR   = 32'h0000_0000;

    // Width of the hold down-counter; large enough for the 1..15 range.
    localparam int HOLD_CNT_W = 4;

endpackage

// File: rtl/imem_array.sv
// Instruction storage: one synchronous write port, one asynchronous read
// port. Contents are deliberately not reset; the loader's fetch guard keeps
// stale words away from the core.
module imem_array #(
    parameter int ADDR_SIZE = 6,
    parameter int DATA_W    = 32
) (
    input  logic                 clock,
    input  logic                 we,
    input  logic [ADDR_SIZE-1:0] waddr,
    input  logic [DATA_W-1:0]    wdata,
    input  logic [ADDR_SIZE-1:0] raddr,
    output logic [DATA_W-1:0]    rdata
);

    logic [DATA_W-1:0] mem [2**ADDR_SIZE];

    // Write port: store the word when the loader accepts a transfer.
    always_ff @(posedge clock) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/imem_loader.sv
// Instruction-memory loader. Accepts a program as a stream of 32-bit words,
// holds the downstream core in reset for a fixed number of cycles after the
// last word, then serves fetches from the loaded region.
//
//   state   | meaning
//   --------+-------------------------------------------------------------
//   LOAD    | accepting words into the store, core held in reset
//   HOLD    | load finished, core kept in reset while hold counter expires
//   RUN     | core released, fetches return loaded words or break
module imem_loader
    import imem_pkg::*;
#(
    parameter int ADDR_SIZE   = 6,
    parameter int HOLD_CYCLES = 4
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 load_valid,
    output logic                 load_ready,
    input  logic [31:0]          load_data,
    input  logic                 load_last,
    input  logic                 reload,
    input  logic [31:0]          raddr,
    output logic [31:0]          instr,
    output logic                 core_reset,
    output logic [ADDR_SIZE:0]   load_count,
    output logic                 overflow
);

    localparam logic [ADDR_SIZE-1:0]  LAST_IDX  = '1;
    localparam logic [HOLD_CNT_W-1:0] HOLD_INIT = HOLD_CNT_W'(HOLD_CYCLES);

    state_t                  state, state_nxt;
    logic [ADDR_SIZE-1:0]    wptr, wptr_nxt;
    logic [ADDR_SIZE:0]      count_nxt;
    logic                    overflow_nxt;
    logic [HOLD_CNT_W-1:0]   hold_cnt, hold_nxt;
    logic                    xfer;
    logic                    fetch_ok;
    logic [31:0]             rdata;

    // Ready is withheld while reset is asserted so nothing is accepted
    // before the block is released.
    assign load_ready = (state == ST_LOAD) && !reset;
    assign xfer       = load_valid && load_ready;
    assign core_reset = (state != ST_RUN);

    imem_array #(
        .ADDR_SIZE (ADDR_SIZE),
        .DATA_W    (32)
    ) u_array (
        .clock (clock),
        .we    (xfer),
        .waddr (wptr),
        .wdata (load_data),
        .raddr (raddr[ADDR_SIZE-1:0]),
        .rdata (rdata)
    );

    // State and bookkeeping registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= ST_LOAD;
            wptr       <= '0;
            load_count <= '0;
            overflow   <= 1'b0;
            hold_cnt   <= '0;
        end else begin
            state      <= state_nxt;
            wptr       <= wptr_nxt;
            load_count <= count_nxt;
            overflow   <= overflow_nxt;
            hold_cnt   <= hold_nxt;
        end
    end

    // Next-state logic: word acceptance in LOAD, hold countdown, reload.
    always_comb begin
        state_nxt    = state;
        wptr_nxt     = wptr;
        count_nxt    = load_count;
        overflow_nxt = overflow;
        hold_nxt     = hold_cnt;

        case (state)
            ST_LOAD: begin
                if (xfer) begin
                    wptr_nxt  = wptr + 1'b1;
                    count_nxt = load_count + 1'b1;
                    if (load_last || (wptr == LAST_IDX)) begin
                        state_nxt    = ST_HOLD;
                        hold_nxt     = HOLD_INIT;
                        // Reaching here without load_last means the store filled up.
                        overflow_nxt = !load_last;
                    end
                end
            end
            ST_HOLD: begin
                if (reload) begin
                    state_nxt    = ST_LOAD;
                    wptr_nxt     = '0;
                    count_nxt    = '0;
                    overflow_nxt = 1'b0;
                    hold_nxt     = '0;
                end else if (hold_cnt <= HOLD_CNT_W'(1)) begin
                    state_nxt = ST_RUN;
                    hold_nxt  = '0;
                end else begin
                    hold_nxt = hold_cnt - 1'b1;
                end
            end
            ST_RUN: begin
                if (reload) begin
                    state_nxt    = ST_LOAD;
                    wptr_nxt     = '0;
                    count_nxt    = '0;
                    overflow_nxt = 1'b0;
                    hold_nxt     = '0;
                end
            end
            default: begin
                state_nxt = ST_LOAD;
            end
        endcase
    end

    assign fetch_ok = (raddr[31:ADDR_SIZE] == '0) &&
                      ({1'b0, raddr[ADDR_SIZE-1:0]} < load_count);

    // Fetch mux: nop while loading/holding, break outside the loaded region.
    always_comb begin
        instr = NOP_INSTR;
        if (state == ST_RUN) begin
            instr = fetch_ok ? rdata : BREAK_INSTR;
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: loaded words are pushed to a
// scoreboard queue as they are driven and compared against instr once the
// core is released.
module tb_imem_loader;

    localparam int AS   = 6;
    localparam int HOLD = 4;
    localparam logic [31:0] BRK = 32'h0000_000D;
    localparam logic [31:0] NOP = 32'h0000_0000;

    logic            clock;
    logic            reset;
    logic            load_valid;
    logic            load_ready;
    logic [31:0]     load_data;
    logic            load_last;
    logic            reload;
    logic [31:0]     raddr;
    logic [31:0]     instr;
    logic            core_reset;
    logic [AS:0]     load_count;
    logic            overflow;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] wr_idx;
    int          n_checks;
    int          n_errors;

    imem_loader #(
        .ADDR_SIZE   (AS),
        .HOLD_CYCLES (HOLD)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .load_data  (load_data),
        .load_last  (load_last),
        .reload     (reload),
        .raddr      (raddr),
        .instr      (instr),
        .core_reset (core_reset),
        .load_count (load_count),
        .overflow   (overflow)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic send_word(input logic [31:0] d, input logic last);
        exp_t e;
        check("load_ready", {31'd0, load_ready}, 32'd1);
        load_valid = 1'b1;
        load_data  = d;
        load_last  = last;
        e.addr = wr_idx;
        e.data = d;
        exp_q.push_back(e);
        wr_idx++;
        tick();
        load_valid = 1'b0;
        load_last  = 1'b0;
        load_data  = 32'hDEAD_BEEF;
    endtask

    // Entered on the first HOLD cycle; leaves the DUT in its first RUN cycle.
    task automatic expect_hold();
        raddr = 32'd0;
        for (int i = 0; i < HOLD; i++) begin
            #0;
            check("core_reset_hold", {31'd0, core_reset}, 32'd1);
            check("instr_hold_nop", instr, NOP);
            tick();
        end
        check("core_reset_run", {31'd0, core_reset}, 32'd0);
    endtask

    task automatic drain_check();
        exp_t e;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            raddr = e.addr;
            #1;
            check("instr_fetch", instr, e.data);
        end
    endtask

    task automatic do_reload();
        reload = 1'b1;
        tick();
        reload = 1'b0;
        wr_idx = 0;
        raddr  = 32'd0;
        #1;
        check("reload_core_reset", {31'd0, core_reset}, 32'd1);
        check("reload_count", {25'd0, load_count}, 32'd0);
        check("reload_overflow", {31'd0, overflow}, 32'd0);
        check("reload_instr", instr, NOP);
        check("reload_ready", {31'd0, load_ready}, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        n_checks   = 0;
        n_errors   = 0;
        wr_idx     = 0;
        reset      = 1'b1;
        load_valid = 1'b0;
        load_data  = 32'd0;
        load_last  = 1'b0;
        reload     = 1'b0;
        raddr      = 32'd0;

        // Reset state
        repeat (3) @(posedge clock);
        #1;
        check("rst_core_reset", {31'd0, core_reset}, 32'd1);
        check("rst_instr", instr, NOP);
        check("rst_count", {25'd0, load_count}, 32'd0);
        check("rst_overflow", {31'd0, overflow}, 32'd0);
        reset = 1'b0;
        #1;
        check("rst_ready", {31'd0, load_ready}, 32'd1);

        // Three-word program, last on the third
        send_word(32'h2001_0005, 1'b0);
        send_word(32'h2002_0007, 1'b0);
        send_word(32'h0000_000D, 1'b1);
        check("p1_ready_hold", {31'd0, load_ready}, 32'd0);
        check("p1_count", {25'd0, load_count}, 32'd3);
        expect_hold();
        check("p1_overflow", {31'd0, overflow}, 32'd0);
        drain_check();
        raddr = 32'd3;
        #1;
        check("p1_beyond_count", instr, BRK);

        // Valid toggling, plus valid while not ready
        do_reload();
        for (int i = 0; i < 4; i++) begin
            send_word(32'hA5A5_0000 + 32'(i), (i == 3));
            if (i < 3) begin
                load_data = 32'hBAD0_0000 + 32'(i);
                tick();
            end
        end
        load_valid = 1'b1;
        load_data  = 32'hBADB_AD00;
        expect_hold();
        load_valid = 1'b0;
        check("p2_count", {25'd0, load_count}, 32'd4);
        drain_check();
        raddr = 32'd4;
        #1;
        check("p2_beyond_count", instr, BRK);

        // Fill the whole store without load_last
        do_reload();
        for (int i = 0; i < 64; i++) begin
            send_word(32'h1000_0000 + 32'(i * 3), 1'b0);
        end
        check("p3_ready_drop", {31'd0, load_ready}, 32'd0);
        check("p3_overflow", {31'd0, overflow}, 32'd1);
        check("p3_count", {25'd0, load_count}, 32'd64);
        load_valid = 1'b1;
        load_data  = 32'hFFFF_0000;
        expect_hold();
        load_valid = 1'b0;
        check("p3_count_run", {25'd0, load_count}, 32'd64);
        drain_check();
        raddr = 32'h0000_0040;
        #1;
        check("p3_addr_40", instr, BRK);
        raddr = 32'h8000_0001;
        #1;
        check("p3_addr_high", instr, BRK);

        // Reload from RUN, single-word program
        do_reload();
        send_word(32'h1234_5678, 1'b1);
        check("p4_count", {25'd0, load_count}, 32'd1);
        expect_hold();
        check("p4_overflow", {31'd0, overflow}, 32'd0);
        drain_check();
        raddr = 32'd1;
        #1;
        check("p4_stale_word", instr, BRK);

        // Reset during the HOLD countdown
        do_reload();
        send_word(32'h5555_AAAA, 1'b0);
        send_word(32'h6666_BBBB, 1'b1);
        tick();
        reset = 1'b1;
        #1;
        check("p5_rst_core_reset", {31'd0, core_reset}, 32'd1);
        check("p5_rst_count", {25'd0, load_count}, 32'd0);
        check("p5_rst_instr", instr, NOP);
        tick();
        reset = 1'b0;
        #1;
        check("p5_ready", {31'd0, load_ready}, 32'd1);
        repeat (HOLD + 2) tick();
        raddr = 32'd0;
        #1;
        check("p5_core_reset_held", {31'd0, core_reset}, 32'd1);
        check("p5_no_fetch", instr, NOP);
        check("p5_count_zero", {25'd0, load_count}, 32'd0);
        exp_q.delete();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
